// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: digit count, blank pattern, hex glyph table.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low g..a glyphs; entry n is the pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Index of the most-significant nonzero nibble; 0 when the word is zero.
    function automatic logic [IDX_W-1:0] top_nibble(input logic [31:0] word);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (word[4*k +: 4] != 4'h0) res = k[IDX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX_SEG_TABLE[nibble_i];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// 8-digit multiplexed hex display scanner with per-frame snapshot of F / M_R_Data and flags.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic [31:0] F,
    input  logic [31:0] M_R_Data,
    input  logic        ZF,
    input  logic        OF,
    input  logic        sel,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        snap_q, snap_d;
    logic [1:0]         flags_q, flags_d;  // {OF, ZF}
    logic [7:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               frame_tick_q, frame_tick_d;

    logic               tick;
    logic               frame;
    logic [31:0]        word_now;
    logic [1:0]         flags_now;
    logic [3:0]         nibble;
    logic [6:0]         digit_seg;
    logic               dp_lit;

    // Digit 0 of a new frame is decoded from the incoming word, not the stale snapshot.
    always_comb begin
        tick      = (presc_q == PRESC_MAX);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        frame     = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
        idx_d     = tick ? idx_q + 1'b1 : idx_q;
        word_now  = frame ? (sel ? M_R_Data : F) : snap_q;
        flags_now = frame ? {OF, ZF} : flags_q;
        snap_d    = word_now;
        flags_d   = flags_now;
        nibble    = word_now[{idx_d, 2'b00} +: 4];
        dp_lit    = ((idx_d == IDX_W'(0)) && flags_now[0]) ||
                    ((idx_d == IDX_W'(1)) && flags_now[1]);
    end

    hex7seg_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (digit_seg)
    );

    always_comb begin
        an_d         = an_q;
        seg_d        = seg_q;
        dp_d         = dp_q;
        frame_tick_d = frame;
        if (tick) begin
            an_d  = ~(8'h01 << idx_d);
            seg_d = digit_seg;
            dp_d  = ~dp_lit;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            // A lit dp keeps its digit enabled with dark segments.
            if (idx_d > top_nibble(word_now)) begin
                seg_d = SEG_BLANK;
                if (!dp_lit) an_d = 8'hFF;
            end
`endif
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= IDX_W'(NUM_DIGITS - 1);
            snap_q       <= '0;
            flags_q      <= '0;
            an_q         <= 8'hFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            flags_q      <= flags_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display with a short refresh divider.
module tb_seg7_scan_display;

    localparam int unsigned DIV = 4;

    localparam logic [6:0] TB_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] F, M_R_Data;
    logic        ZF, OF, sel;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_tick;

    always #5 clk = ~clk;

    seg7_scan_display #(.REFRESH_DIV(DIV)) dut (
        .clk_100MHz (clk),
        .rst        (rst),
        .F          (F),
        .M_R_Data   (M_R_Data),
        .ZF         (ZF),
        .OF         (OF),
        .sel        (sel),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    int          tests = 0;
    int          fails = 0;
    logic [15:0] sb [$];
    logic [15:0] cap [8];
    logic [31:0] cap_f;
    int          cap_cyc;
    int          cyc = 0;
    logic [31:0] f_hist = '0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        f_hist <= F;
    end

    // Expected {an, seg, dp} for digit slot k of a frame showing word w.
    function automatic logic [15:0] exp_slot(input logic [31:0] w, input logic zf,
                                             input logic of, input int k);
        logic [7:0] a;
        logic [6:0] s;
        logic       d;
        int         msn;
        a   = ~(8'h01 << k);
        s   = TB_HEX[w[4*k +: 4]];
        d   = !((k == 0 && zf) || (k == 1 && of));
        msn = 0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        for (int j = 0; j < 8; j++) if (w[4*j +: 4] != 4'h0) msn = j;
        if (k > msn) begin
            s = 7'h7F;
            if (d) a = 8'hFF;
        end
`endif
        return {a, s, d};
    endfunction

    task automatic push_frame(input logic [31:0] w, input logic zf, input logic of);
        for (int k = 0; k < 8; k++) sb.push_back(exp_slot(w, zf, of, k));
    endtask

    // Waits (bounded) for the next frame_tick, then samples all 8 digit slots.
    task automatic capture_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 80);
        if (frame_tick !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL frame_tick_timeout: got frame_tick=%b, want 1 within 80 cycles",
                     frame_tick);
        end
        cap_f   = f_hist;
        cap_cyc = cyc;
        for (int k = 0; k < 8; k++) begin
            cap[k] = {an, seg, dp};
            if (k < 7) repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; F = '0; M_R_Data = '0; sel = 1'b0; ZF = 1'b0; OF = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if ({an, seg, dp, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL reset_hold: got an=%h seg=%h dp=%b ft=%b, want FF 7F 1 0",
                         an, seg, dp, frame_tick);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            tests++;
            if ({an, seg, dp, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got an=%h seg=%h dp=%b ft=%b, want FF 7F 1 0",
                         i, an, seg, dp, frame_tick);
            end
        end
        @(negedge clk);
        tests++;
        if ({an, seg, dp, frame_tick} !== {8'hFE, 7'h40, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL reset_first_tick: got an=%h seg=%h dp=%b ft=%b, want FE 40 1 1",
                     an, seg, dp, frame_tick);
        end
    endtask

    task automatic test_hex_digits();
        logic [15:0] e;
        F = 32'h1234_ABCD; sel = 1'b0; ZF = 1'b0; OF = 1'b0;
        push_frame(F, 1'b0, 1'b0);
        capture_frame();
        for (int k = 0; k < 8; k++) begin
            e = sb.pop_front();
            tests++;
            if (cap[k] !== e) begin
                fails++;
                $display("FAIL hex_digits d%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                         k, cap[k][15:8], cap[k][7:1], cap[k][0], e[15:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_sel_midframe();
        logic [15:0] e;
        F = 32'h1234_ABCD; M_R_Data = 32'hDEAD_BEEF; sel = 1'b0;
        push_frame(F, 1'b0, 1'b0);
        fork
            capture_frame();
            begin
                repeat (14) @(negedge clk);
                sel = 1'b1;
            end
        join
        push_frame(M_R_Data, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            e = sb.pop_front();
            tests++;
            if (cap[k] !== e) begin
                fails++;
                $display("FAIL sel_midframe d%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                         k, cap[k][15:8], cap[k][7:1], cap[k][0], e[15:8], e[7:1], e[0]);
            end
        end
        capture_frame();
        for (int k = 0; k < 8; k++) begin
            e = sb.pop_front();
            tests++;
            if (cap[k] !== e) begin
                fails++;
                $display("FAIL sel_next_frame d%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                         k, cap[k][15:8], cap[k][7:1], cap[k][0], e[15:8], e[7:1], e[0]);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_flags();
        logic [15:0] e;
        F = 32'h8765_4321;
        for (int p = 0; p < 2; p++) begin
            ZF = 1'b1;
            OF = (p == 0);
            push_frame(F, ZF, OF);
            capture_frame();
            for (int k = 0; k < 8; k++) begin
                e = sb.pop_front();
                tests++;
                if (cap[k] !== e) begin
                    fails++;
                    $display("FAIL flags p%0d d%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                             p, k, cap[k][15:8], cap[k][7:1], cap[k][0], e[15:8], e[7:1], e[0]);
                end
            end
        end
        ZF = 1'b0; OF = 1'b0;
    endtask

    task automatic test_frame_snapshot();
        logic [15:0] e;
        int          first_cyc;
        F = 32'h0000_0FF0;
        fork
            repeat (80) begin
                @(negedge clk);
                F = F + 1;
            end
            begin
                for (int fr = 0; fr < 2; fr++) begin
                    capture_frame();
                    if (fr == 0) first_cyc = cap_cyc;
                    push_frame(cap_f, 1'b0, 1'b0);
                    for (int k = 0; k < 8; k++) begin
                        e = sb.pop_front();
                        tests++;
                        if (cap[k] !== e) begin
                            fails++;
                            $display("FAIL snapshot f%0d d%0d: got an=%h seg=%h, want an=%h seg=%h (word %h)",
                                     fr, k, cap[k][15:8], cap[k][7:1], e[15:8], e[7:1], cap_f);
                        end
                    end
                end
                tests++;
                if (cap_cyc - first_cyc != 32) begin
                    fails++;
                    $display("FAIL frame_period: got %0d cycles, want 32", cap_cyc - first_cyc);
                end
            end
        join
    endtask

    task automatic test_leading_zero();
        logic [15:0] e;
        for (int p = 0; p < 2; p++) begin
            F  = (p == 0) ? 32'h0000_00A5 : 32'h0000_0003;
            OF = (p == 1);
            push_frame(F, 1'b0, OF);
            capture_frame();
            for (int k = 0; k < 8; k++) begin
                e = sb.pop_front();
                tests++;
                if (cap[k] !== e) begin
                    fails++;
                    $display("FAIL leading_zero p%0d d%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                             p, k, cap[k][15:8], cap[k][7:1], cap[k][0], e[15:8], e[7:1], e[0]);
                end
            end
        end
        OF = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 80);
        tests++;
        if (frame_tick !== 1'b1) begin
            fails++;
            $display("FAIL midreset_wait: got frame_tick=%b, want 1 within 80 cycles", frame_tick);
        end
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({an, seg, dp, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL midreset_abort: got an=%h seg=%h dp=%b ft=%b, want FF 7F 1 0",
                     an, seg, dp, frame_tick);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({an, frame_tick} !== {8'hFF, 1'b0}) begin
            fails++;
            $display("FAIL midreset_idle: got an=%h ft=%b, want FF 0", an, frame_tick);
        end
        @(negedge clk);
        tests++;
        if ({an, frame_tick} !== {8'hFE, 1'b1}) begin
            fails++;
            $display("FAIL midreset_restart: got an=%h ft=%b, want FE 1", an, frame_tick);
        end
    endtask

    initial begin
        test_reset();
        test_hex_digits();
        test_sel_midframe();
        test_flags();
        test_frame_snapshot();
        test_leading_zero();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream display stage for the R/I-type CPU top.
- Consumes the ALU result F, the memory read data M_R_Data and the ZF/OF flags, and drives the board's 8-digit multiplexed seven-segment display in hex.
- Runs on the 100 MHz board clock and scans one digit at a time.
- Snapshots the selected word once per frame so that a value changing mid-scan never tears on the display.

Parameters:
- REFRESH_DIV, 100000, clk_100MHz cycles per digit slot (1 kHz per digit, 125 Hz frame). Legal range is 2 or more.

Ports:
- clk_100MHz  in   1   board clock; the only clock in this block
- rst         in   1   reset
- F           in   32  ALU result from CPU
- M_R_Data    in   32  data-memory read word from CPU
- ZF          in   1   zero flag
- OF          in   1   overflow flag
- sel         in   1   0 = show F, 1 = show M_R_Data
- an          out  8   digit enables, active-low; an[0] = rightmost digit
- seg         out  7   segments, active-low, seg[6:0] = g..a
- dp          out  1   decimal point, active-low
- frame_tick  out  1   one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset is synchronous, active-high, on clk_100MHz. During and after reset, until the first tick:
  - an = 8'hFF, seg = 7'h7F, dp = 1, frame_tick = 0.
  - Prescaler = 0, digit index idx = 7, snapshot word = 0, snapshot flags = 0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler == REFRESH_DIV-1).
- On each tick:
  - idx <= idx + 1 mod 8.
  - an, seg and dp are all registered on that same edge for the new idx. Exactly one an bit is low, except where a digit is blanked.
- Frame boundary is the tick on which idx goes 7 -> 0. On that edge:
  - snap <= (sel ? M_R_Data : F); snapflags <= {OF, ZF}; frame_tick <= 1 for one cycle.
  - The digit-0 outputs are computed from the incoming value (bypass), not the old snapshot.
- Digit k shows hex nibble snap[4k+3:4k].
- dp is low only on digit 0 when ZF_snap = 1, and only on digit 1 when OF_snap = 1.
- Latency: an input change appears at the next frame boundary, so at most 8*REFRESH_DIV cycles later.
- Changes to sel, F or the flags mid-frame are ignored until the boundary.
- Reset asserted mid-frame aborts the scan immediately. The next frame starts from idx 0 after REFRESH_DIV cycles.
- The first tick after reset is a frame boundary, because idx resets to 7.
- Hex patterns (active-low, g..a):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined: digits above the most-significant nonzero nibble of snap are blanked (an bit high, seg = 7'h7F). A dp that would be lit still lights on digit 1 with an low and seg = 7'h7F. Digit 0 is never blanked.
- When undefined: all 8 digits always display, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - NUM_DIGITS = 8.
  - SEG_BLANK = 7'h7F.
  - The 16-entry hex-to-segment constant table.
- One sub-module, hex7seg_decode: a 4-bit nibble in, 7-bit active-low segment out, purely combinational.
- Scanner, snapshot and blanking logic live in seg7_scan_display.

Test Plan (all with REFRESH_DIV = 4):
- rst = 1 for 3 cycles, then released -> an = FF, seg = 7F, dp = 1 until the 4th cycle after release; then frame_tick pulses and an = FE.
- F = 0x1234ABCD, sel = 0, ZF = OF = 0 -> digit 0 shows an = FE, seg = 21; digit 7 (ticks later) shows an = 7F, seg = 79. Digit slots are 4 cycles apart; dp stays 1.
- sel flips to 1 mid-frame with M_R_Data = 0xDEADBEEF -> remaining digits of the current frame still show F's nibbles; the next frame's digit 0 shows seg = 0E.
- ZF = 1, OF = 1 -> dp = 0 on the digit-0 and digit-1 slots only; ZF = 1, OF = 0 -> dp = 0 on digit 0 only.
- F incremented every cycle -> all 8 digits of a frame equal the value sampled on the frame_tick edge. frame_tick period = 32 cycles.
- F = 0x000000A5:
  - Without the macro, digits 2..7 show seg = 40.
  - With SEG7_LEADING_ZERO_BLANK_EN, digits 2..7 have an bit = 1 and seg = 7F; digits 1 and 0 show 08 and 12.
